// File: rtl/digit_scan_pkg.sv
// digit_scan_pkg: shared constants, segment table and digit search for the digit scanner
package digit_scan_pkg;
  localparam int N_DIGITS = 8;
  localparam logic [7:0] SEG_OFF_LOW = 8'hFF;
  localparam logic [7:0] SEG_OFF_HIGH = 8'h00;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic logic [2:0] next_idx(input logic [N_DIGITS-1:0] m, input logic [2:0] c);
    next_idx = c;
    for (int k = N_DIGITS - 1; k >= 1; k--)
      if (m[c + 3'(k)]) next_idx = c + 3'(k);
  endfunction
endpackage

// File: rtl/hex7seg.sv
// hex7seg: nibble plus decimal point to active-high {dp,g,f,e,d,c,b,a} pattern
module hex7seg
  import digit_scan_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);
  assign seg = {dp, HEX_SEG[nib]};
endmodule

// File: rtl/digit_scan8.sv
// digit_scan8: eight-digit multiplexed 7-segment scanner with frame-synchronous double buffering and blanking
module digit_scan8
  import digit_scan_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int BLANK_CYC = 16,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_data,
  input  logic [7:0]  i_dp,
  input  logic [7:0]  i_en_mask,
  input  logic        i_load,
  input  logic        i_opt,
  output logic [2:0]  o_sel,
  output logic        o_opt,
  output logic [7:0]  o_seg,
  output logic        o_frame,
  output logic        o_load_ack
);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BLANK = PW'(BLANK_CYC);
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? SEG_OFF_LOW : SEG_OFF_HIGH;
  logic [PW-1:0] cnt, cnt_n;
  logic [2:0] sel_n, nxt;
  logic [31:0] act_data, pend_data, data_n;
  logic [N_DIGITS-1:0] act_dp, act_mask, pend_dp, pend_mask, dp_n, mask_n;
  logic [7:0] pat, seg_n;
  logic pend, tick, wrap, commit;
  always_comb begin
    tick = cnt == LAST;
    nxt = next_idx(act_mask, o_sel);
    wrap = tick && (act_mask == '0 || nxt <= o_sel);
    commit = wrap && pend;
    data_n = commit ? pend_data : act_data;
    dp_n = commit ? pend_dp : act_dp;
    mask_n = commit ? pend_mask : act_mask;
    cnt_n = tick ? '0 : cnt + 1'b1;
    sel_n = !tick ? o_sel : !wrap ? nxt : mask_n == '0 ? 3'd0 : next_idx(mask_n, 3'd7);
  end
  hex7seg u_hex (
    .nib(data_n[{sel_n, 2'b00} +: 4]),
    .dp (dp_n[sel_n]),
    .seg(pat)
  );
  assign seg_n = (cnt_n < BLANK || mask_n == '0) ? SEG_OFF : SEG_ACTIVE_LOW ? ~pat : pat;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cnt <= '0;
      o_sel <= '0;
      o_opt <= 1'b0;
      o_seg <= SEG_OFF;
      o_frame <= 1'b0;
      o_load_ack <= 1'b0;
      act_data <= '0;
      act_dp <= '0;
      act_mask <= '1;
      pend <= 1'b0;
      pend_data <= '0;
      pend_dp <= '0;
      pend_mask <= '0;
    end else begin
      cnt <= cnt_n;
      o_sel <= sel_n;
      o_opt <= i_opt;
      o_seg <= seg_n;
      o_frame <= wrap;
      o_load_ack <= commit;
      act_data <= data_n;
      act_dp <= dp_n;
      act_mask <= mask_n;
      pend <= i_load || (pend && !commit);
      if (i_load) begin
        pend_data <= i_data;
        pend_dp <= i_dp;
        pend_mask <= i_en_mask;
      end
    end
endmodule

// File: tb/tb_digit_scan8.sv
// tb_digit_scan8: scoreboard bench; each slot change or frame pulse pops one expected record
module tb_digit_scan8;
  typedef struct {
    logic [2:0] sel;
    logic       frame;
    logic       ack;
    logic [7:0] seg;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] i_data = '0;
  logic [7:0] i_dp = '0;
  logic [7:0] i_en_mask = '0;
  logic i_load = 1'b0;
  logic i_opt = 1'b1;
  logic [2:0] o_sel;
  logic o_opt;
  logic [7:0] o_seg;
  logic o_frame;
  logic o_load_ack;
  exp_t sb[$];
  exp_t cur;
  int passed = 0;
  int total = 0;
  bit mon_en = 1'b0;
  bit chk_seg = 1'b0;
  bit ev;
  logic [2:0] prev_sel = '0;
  digit_scan8 #(.CLK_DIV(4), .BLANK_CYC(1), .SEG_ACTIVE_LOW(1)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_data(i_data),
    .i_dp(i_dp),
    .i_en_mask(i_en_mask),
    .i_load(i_load),
    .i_opt(i_opt),
    .o_sel(o_sel),
    .o_opt(o_opt),
    .o_seg(o_seg),
    .o_frame(o_frame),
    .o_load_ack(o_load_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask
  task automatic push(input logic [2:0] s, input logic f, input logic a, input logic [7:0] g);
    exp_t e;
    e.sel = s;
    e.frame = f;
    e.ack = a;
    e.seg = g;
    sb.push_back(e);
  endtask
  task automatic load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] m);
    i_data = d;
    i_dp = dp;
    i_en_mask = m;
    i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
  endtask
  task automatic wait_frame();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_frame) return;
    end
    total++;
    $display("FAIL wait_frame: timeout, no o_frame pulse");
  endtask
  task automatic wait_sel(input logic [2:0] s);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_sel == s) return;
    end
    total++;
    $display("FAIL wait_sel: timeout waiting for o_sel=%0d, got %0d", s, o_sel);
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      if (chk_seg) begin
        chk("seg_digit", o_seg, cur.seg);
        chk_seg = 1'b0;
      end
      ev = (o_sel != prev_sel) || o_frame;
      if (ev) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL sb_empty: unexpected slot sel=%0d frame=%0b ack=%0b", o_sel, o_frame, o_load_ack);
        end else begin
          cur = sb.pop_front();
          chk("sel", {5'd0, o_sel}, {5'd0, cur.sel});
          chk("frame", {7'd0, o_frame}, {7'd0, cur.frame});
          chk("load_ack", {7'd0, o_load_ack}, {7'd0, cur.ack});
          chk("seg_blank", o_seg, 8'hFF);
          chk_seg = 1'b1;
        end
      end else if (o_load_ack) begin
        total++;
        $display("FAIL stray_ack: o_load_ack got 1 expected 0 (sel=%0d)", o_sel);
      end
      prev_sel = o_sel;
    end
  end
  initial begin
    #12;
    chk("rst_sel", {5'd0, o_sel}, 8'd0);
    chk("rst_seg", o_seg, 8'hFF);
    chk("rst_frame", {7'd0, o_frame}, 8'd0);
    chk("rst_ack", {7'd0, o_load_ack}, 8'd0);
    chk("rst_opt", {7'd0, o_opt}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 1; s < 8; s++) push(3'(s), 1'b0, 1'b0, 8'hC0);
    push(3'd0, 1'b1, 1'b0, 8'hC0);
    for (int s = 1; s < 8; s++) push(3'(s), 1'b0, 1'b0, 8'hC0);
    push(3'd0, 1'b1, 1'b1, 8'h40);
    prev_sel = '0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("first_slot_seg", o_seg, 8'hC0);
    chk("opt_follow_1", {7'd0, o_opt}, 8'd1);
    i_opt = 1'b0;
    @(negedge clk);
    chk("opt_follow_0", {7'd0, o_opt}, 8'd0);
    wait_frame();
    wait_sel(3'd3);
    load(32'h7654_3210, 8'h01, 8'hFF);
    push(3'd1, 1'b0, 1'b0, 8'hF9);
    push(3'd2, 1'b0, 1'b0, 8'hA4);
    push(3'd3, 1'b0, 1'b0, 8'hB0);
    push(3'd4, 1'b0, 1'b0, 8'h99);
    push(3'd5, 1'b0, 1'b0, 8'h92);
    push(3'd6, 1'b0, 1'b0, 8'h82);
    push(3'd7, 1'b0, 1'b0, 8'hF8);
    push(3'd2, 1'b1, 1'b1, 8'hA4);
    push(3'd7, 1'b0, 1'b0, 8'hF8);
    push(3'd2, 1'b1, 1'b0, 8'hA4);
    push(3'd7, 1'b0, 1'b0, 8'hF8);
    push(3'd2, 1'b1, 1'b0, 8'hA4);
    wait_frame();
    load(32'h7654_3210, 8'h00, 8'h84);
    repeat (3) wait_frame();
    load(32'h1111_1111, 8'h00, 8'hFF);
    load(32'h2222_2222, 8'h00, 8'hFF);
    push(3'd7, 1'b0, 1'b0, 8'hF8);
    push(3'd0, 1'b1, 1'b1, 8'hA4);
    for (int s = 1; s < 8; s++) push(3'(s), 1'b0, 1'b0, 8'hA4);
    wait_frame();
    load(32'h3333_3333, 8'h00, 8'hFF);
    push(3'd0, 1'b1, 1'b1, 8'hB0);
    for (int s = 1; s < 8; s++) push(3'(s), 1'b0, 1'b0, 8'hB0);
    push(3'd0, 1'b1, 1'b1, 8'h99);
    for (int s = 1; s < 8; s++) push(3'(s), 1'b0, 1'b0, 8'h99);
    wait_sel(3'd7);
    repeat (3) @(negedge clk);
    load(32'h4444_4444, 8'h00, 8'hFF);
    wait_frame();
    load(32'h4444_4444, 8'h00, 8'h00);
    push(3'd0, 1'b1, 1'b1, 8'hFF);
    push(3'd0, 1'b1, 1'b0, 8'hFF);
    push(3'd0, 1'b1, 1'b0, 8'hFF);
    repeat (3) wait_frame();
    load(32'h4444_4444, 8'h00, 8'h10);
    push(3'd4, 1'b1, 1'b1, 8'h99);
    push(3'd4, 1'b1, 1'b0, 8'h99);
    repeat (2) wait_frame();
    load(32'h4444_4444, 8'h00, 8'hFF);
    push(3'd0, 1'b1, 1'b1, 8'h99);
    for (int s = 1; s < 6; s++) push(3'(s), 1'b0, 1'b0, 8'h99);
    i_opt = 1'b1;
    wait_sel(3'd5);
    load(32'h5555_5555, 8'hFF, 8'hFF);
    @(posedge clk);
    mon_en = 1'b0;
    chk("sb_drained", 8'(sb.size()), 8'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sel", {5'd0, o_sel}, 8'd0);
    chk("async_rst_seg", o_seg, 8'hFF);
    chk("async_rst_frame", {7'd0, o_frame}, 8'd0);
    chk("async_rst_ack", {7'd0, o_load_ack}, 8'd0);
    chk("async_rst_opt", {7'd0, o_opt}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    i_opt = 1'b0;
    for (int s = 1; s < 8; s++) push(3'(s), 1'b0, 1'b0, 8'hC0);
    push(3'd0, 1'b1, 1'b0, 8'hC0);
    prev_sel = '0;
    chk_seg = 1'b0;
    mon_en = 1'b1;
    wait_frame();
    @(negedge clk);
    chk("sb_final_drained", 8'(sb.size()), 8'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/digit_scan8.md
Name: digit_scan8

Overview:
- Upstream driver for the 3-to-8 digit-select decoder in the 7-segment display path.
- Time-multiplexes eight hex digits. Produces the 3-bit digit select (o_sel) and polarity flag (o_opt) consumed by the decoder, plus the matching segment pattern.
- Double-buffers display data so updates land only on frame boundaries.
- Inserts a blanking dead-time at each digit change to suppress ghosting.

Parameters:
- CLK_DIV, 50000: clock cycles per digit slot. Must be >= 2.
- BLANK_CYC, 16: cycles at the start of each slot during which segments are forced off. Must be < CLK_DIV.
- SEG_ACTIVE_LOW, 1: 1 means o_seg is active-low (off = 8'hFF); 0 means active-high (off = 8'h00).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_data  in  32  digit k nibble = i_data[4k+3:4k], k = 0..7
- i_dp  in  8  decimal point per digit
- i_en_mask  in  8  digit enable per digit
- i_load  in  1  one-cycle strobe; captures i_data, i_dp, i_en_mask
- i_opt  in  1  select-polarity request, forwarded to decoder
- o_sel  out  3  current digit index, to decoder select input
- o_opt  out  1  registered copy of i_opt
- o_seg  out  8  {dp,g,f,e,d,c,b,a}
- o_frame  out  1  one-cycle pulse at each frame start
- o_load_ack  out  1  one-cycle pulse when pending data is committed

Behaviour:
- Reset (async, i_rst_n=0):
  - prescaler = 0, o_sel = 0, o_opt = 0, o_seg = off, o_frame = 0, o_load_ack = 0.
  - active data = 0, active dp = 0, active mask = 8'hFF; pending flag = 0.
  - Reset mid-operation aborts the slot immediately; no commit occurs.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - "Tick" is the cycle with prescaler == CLK_DIV-1.
  - A new slot begins on the edge after the tick.
- Digit advance on tick:
  - o_sel moves to the next index above the current one (ascending, mod 8) whose active-mask bit is 1.
  - If the current index is the only enabled digit, o_sel is unchanged.
- Frame wrap:
  - Occurs when the chosen next index <= current index; also on every tick when the active mask is 0.
  - On the slot-start edge after a wrap, o_frame = 1 for one cycle.
- Commit (frame wrap only):
  - If pending = 1, the pending registers are copied to active on the same edge as the frame wrap; o_load_ack = 1 for one cycle; pending is cleared.
  - The next-index search uses the NEW mask. The first enabled index from 0 is chosen; o_sel = 0 if the new mask is 0.
- Load:
  - i_load = 1 copies inputs to the pending registers and sets pending = 1.
  - A second load before commit overwrites pending; only the last load is committed.
  - Load in the same cycle as a commit: the old pending commits, the new data becomes pending, and pending stays 1.
- Segments (registered; updates on the same edges as o_sel):
  - While prescaler < BLANK_CYC, or active mask = 0: o_seg = off.
  - Otherwise o_seg = hex pattern of the active nibble at o_sel, with dp = active dp[o_sel], inverted when SEG_ACTIVE_LOW = 1.
- Hex patterns, active-high gfedcba:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71
- o_opt: follows i_opt with a one-cycle register delay, independent of the slot timing.
- Latency:
  - Digit content is visible BLANK_CYC cycles after the slot start.
  - With BLANK_CYC = 0, o_seg changes on the same edge as o_sel.

Decomposition:
- Package digit_scan_pkg holds:
  - the 16-entry hex-to-segment constant table,
  - SEG_OFF_LOW / SEG_OFF_HIGH constants,
  - the digit-count constant (8).
- One combinational sub-module, hex7seg: 4-bit nibble + dp in, 8-bit active-high pattern out.
- Scan, buffering and blanking logic live in digit_scan8.

Test Plan:
1. CLK_DIV=4, BLANK_CYC=1, reset release, no load:
   - o_sel steps 0,1,…,7,0 every 4 cycles.
   - o_seg = 8'hFF in the first cycle of each slot, then 8'hC0 (digit "0", active-low).
   - o_frame pulses once per 32 cycles.
2. Load i_data=32'h76543210, i_dp=8'h01, mask=8'hFF while o_sel=3:
   - o_load_ack and o_frame pulse together at the next wrap to 0; no earlier change in o_seg.
   - Digit 0 then shows 8'h40 (0 with dp, active-low); digit 5 shows 8'h92.
3. Mask 8'b1000_0100:
   - o_sel sequence is 2,7,2,7; o_frame pulses on each 7→2 transition.
4. Two loads before the wrap (data 32'h1111_1111, then 32'h2222_2222):
   - Exactly one o_load_ack; all digits show 8'hA4.
   - Load coincident with the commit edge: pending stays set and commits at the following wrap.
5. Mask 8'h00 committed:
   - o_seg stays 8'hFF, o_sel = 0, o_frame pulses every tick.
   - Recovery via load of mask 8'h10: o_sel = 4 after the next tick.
6. Assert i_rst_n low mid-slot (prescaler=2, o_sel=5):
   - Outputs go to reset values asynchronously, without waiting for a clock edge.
   - Pending data is discarded; scanning restarts at o_sel = 0.
